// File: rtl/coretest_pkg.sv
// Shared constants, encodings and frame-layout helpers for the coretest host.
package coretest_pkg;

  // Command codes carried in the second byte of a command frame
  localparam logic [7:0] CMD_READ  = 8'h10;
  localparam logic [7:0] CMD_WRITE = 8'h11;
  localparam logic [7:0] CMD_RESET = 8'h01;

  // Response codes carried in the second byte of a response frame
  localparam logic [7:0] RSPC_READ   = 8'h7f;
  localparam logic [7:0] RSPC_WRITE  = 8'h7e;
  localparam logic [7:0] RSPC_RESET  = 8'h7d;
  localparam logic [7:0] RSPC_ERR_FD = 8'hfd;
  localparam logic [7:0] RSPC_ERR_FE = 8'hfe;

  // Default framing bytes
  localparam logic [7:0] DEF_SOC     = 8'h55;
  localparam logic [7:0] DEF_EOC     = 8'haa;
  localparam logic [7:0] DEF_RSP_SOC = 8'haa;
  localparam logic [7:0] DEF_RSP_EOC = 8'h55;

  typedef enum logic [1:0] {
    REQ_READ  = 2'd0,
    REQ_WRITE = 2'd1,
    REQ_RESET = 2'd2,
    REQ_RSVD  = 2'd3
  } req_e;

  typedef enum logic [1:0] {
    STATUS_OK        = 2'd0,
    STATUS_CORE_ERR  = 2'd1,
    STATUS_FRAME_ERR = 2'd2,
    STATUS_TIMEOUT   = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TX_BYTE = 3'd1,
    ST_TX_WAIT = 3'd2,
    ST_RX_BYTE = 3'd3,
    ST_PARSE   = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  function automatic logic [7:0] cmd_code(input req_e r);
    case (r)
      REQ_WRITE: cmd_code = CMD_WRITE;
      REQ_RESET: cmd_code = CMD_RESET;
      default:   cmd_code = CMD_READ;
    endcase
  endfunction

  function automatic logic [7:0] rsp_code(input req_e r);
    case (r)
      REQ_WRITE: rsp_code = RSPC_WRITE;
      REQ_RESET: rsp_code = RSPC_RESET;
      default:   rsp_code = RSPC_READ;
    endcase
  endfunction

  // Index of the final byte of the outgoing command frame
  function automatic logic [3:0] tx_last(input req_e r);
    case (r)
      REQ_WRITE: tx_last = 4'd8;
      REQ_RESET: tx_last = 4'd2;
      default:   tx_last = 4'd4;
    endcase
  endfunction

  // Index of the final byte of a successful response frame
  function automatic logic [3:0] rx_last(input req_e r);
    case (r)
      REQ_WRITE: rx_last = 4'd4;
      REQ_RESET: rx_last = 4'd2;
      default:   rx_last = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/coretest_byte_rx.sv
// Receive-side syn/ack byte acceptor: registers a byte, pulses ack for one
// cycle, and re-arms only once the sender has dropped syn.
module coretest_byte_rx (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_syn,
  input  logic [7:0] i_data,
  output logic       o_ack,
  output logic       o_valid,
  output logic [7:0] o_data
);

  logic       r_ack;
  logic       r_armed;
  logic [7:0] r_data;

  // Capture on syn while armed; the ack pulse doubles as the byte-valid strobe
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ack   <= 1'b0;
      r_armed <= 1'b1;
      r_data  <= 8'h00;
    end else begin
      r_ack <= 1'b0;
      if (i_syn && !r_ack && r_armed) begin
        r_data  <= i_data;
        r_ack   <= 1'b1;
        r_armed <= 1'b0;
      end else if (!i_syn) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_ack   = r_ack;
  assign o_valid = r_ack;
  assign o_data  = r_data;

endmodule

// File: rtl/coretest_host.sv
// Host side of the coretest protocol: serialises one register request into a
// command frame and parses the matching response frame.
module coretest_host #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000,
  parameter logic [7:0]  SOC            = coretest_pkg::DEF_SOC,
  parameter logic [7:0]  EOC            = coretest_pkg::DEF_EOC,
  parameter logic [7:0]  RSP_SOC        = coretest_pkg::DEF_RSP_SOC,
  parameter logic [7:0]  RSP_EOC        = coretest_pkg::DEF_RSP_EOC
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [1:0]  i_req_cmd,
  input  logic [15:0] i_req_address,
  input  logic [31:0] i_req_write_data,
  output logic        o_resp_valid,
  output logic [1:0]  o_resp_status,
  output logic [31:0] o_resp_read_data,
  output logic        o_tx_syn,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ack,
  input  logic        i_rx_syn,
  input  logic [7:0]  i_rx_data,
  output logic        o_rx_ack,
  output logic        o_busy
);
  import coretest_pkg::*;

  state_e      r_state,     w_state_next;
  req_e        r_cmd,       w_cmd_next;
  logic [15:0] r_addr,      w_addr_next;
  logic [31:0] r_wdata,     w_wdata_next;
  logic [3:0]  r_idx,       w_idx_next;
  logic [31:0] r_rdata,     w_rdata_next;
  logic        r_core_err,  w_core_err_next;
  logic [31:0] r_timer,     w_timer_next;
  status_e     r_status,    w_status_next;
  logic [31:0] r_resp_data, w_resp_data_next;
  logic        w_frame_err;
  logic        w_rx_valid;
  logic [7:0]  w_rx_byte;
  logic [7:0]  w_tx_byte;

  coretest_byte_rx u_byte_rx (
    .i_clk   (i_clk),
    .i_rst_n (i_reset_n),
    .i_syn   (i_rx_syn),
    .i_data  (i_rx_data),
    .o_ack   (o_rx_ack),
    .o_valid (w_rx_valid),
    .o_data  (w_rx_byte)
  );

  // State and datapath registers; reset aborts any frame in flight
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= ST_IDLE;
      r_cmd       <= REQ_READ;
      r_addr      <= 16'h0000;
      r_wdata     <= 32'h0;
      r_idx       <= 4'd0;
      r_rdata     <= 32'h0;
      r_core_err  <= 1'b0;
      r_timer     <= 32'h0;
      r_status    <= STATUS_OK;
      r_resp_data <= 32'h0;
    end else begin
      r_state     <= w_state_next;
      r_cmd       <= w_cmd_next;
      r_addr      <= w_addr_next;
      r_wdata     <= w_wdata_next;
      r_idx       <= w_idx_next;
      r_rdata     <= w_rdata_next;
      r_core_err  <= w_core_err_next;
      r_timer     <= w_timer_next;
      r_status    <= w_status_next;
      r_resp_data <= w_resp_data_next;
    end
  end

  // Select the command-frame byte at the current index
  always_comb begin
    w_tx_byte = 8'h00;
    if (r_idx == 4'd0) begin
      w_tx_byte = SOC;
    end else if (r_idx == 4'd1) begin
      w_tx_byte = cmd_code(r_cmd);
    end else if (r_idx == tx_last(r_cmd)) begin
      w_tx_byte = EOC;
    end else begin
      case (r_idx)
        4'd2:    w_tx_byte = r_addr[15:8];
        4'd3:    w_tx_byte = r_addr[7:0];
        4'd4:    w_tx_byte = r_wdata[31:24];
        4'd5:    w_tx_byte = r_wdata[23:16];
        4'd6:    w_tx_byte = r_wdata[15:8];
        4'd7:    w_tx_byte = r_wdata[7:0];
        default: w_tx_byte = 8'h00;
      endcase
    end
  end

  // Next-state logic: transmit frame, collect response, check each byte in turn
  always_comb begin
    w_state_next     = r_state;
    w_cmd_next       = r_cmd;
    w_addr_next      = r_addr;
    w_wdata_next     = r_wdata;
    w_idx_next       = r_idx;
    w_rdata_next     = r_rdata;
    w_core_err_next  = r_core_err;
    w_timer_next     = r_timer;
    w_status_next    = r_status;
    w_resp_data_next = r_resp_data;
    w_frame_err      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_req_valid) begin
          w_cmd_next      = (i_req_cmd == 2'd3) ? REQ_READ : req_e'(i_req_cmd);
          w_addr_next     = i_req_address;
          w_wdata_next    = i_req_write_data;
          w_idx_next      = 4'd0;
          w_rdata_next    = 32'h0;
          w_core_err_next = 1'b0;
          w_state_next    = ST_TX_BYTE;
        end
      end
      ST_TX_BYTE: begin
        if (i_tx_ack) w_state_next = ST_TX_WAIT;
      end
      ST_TX_WAIT: begin
        if (!i_tx_ack) begin
          if (r_idx == tx_last(r_cmd)) begin
            w_idx_next   = 4'd0;
            w_timer_next = 32'h0;
            w_state_next = ST_RX_BYTE;
          end else begin
            w_idx_next   = r_idx + 4'd1;
            w_state_next = ST_TX_BYTE;
          end
        end
      end
      ST_RX_BYTE: begin
        if (w_rx_valid) begin
          w_timer_next = 32'h0;
          w_state_next = ST_PARSE;
        end else if (r_timer >= TIMEOUT_CYCLES - 32'd1) begin
          w_status_next    = STATUS_TIMEOUT;
          w_resp_data_next = 32'h0;
          w_state_next     = ST_DONE;
        end else begin
          w_timer_next = r_timer + 32'd1;
        end
      end
      ST_PARSE: begin
        w_idx_next   = r_idx + 4'd1;
        w_timer_next = 32'h0;
        w_state_next = ST_RX_BYTE;
        if (r_idx == 4'd0) begin
          if (w_rx_byte != RSP_SOC) w_frame_err = 1'b1;
        end else if (r_idx == 4'd1) begin
          if (w_rx_byte == RSPC_ERR_FD || w_rx_byte == RSPC_ERR_FE) begin
            w_core_err_next = 1'b1;
          end else if (w_rx_byte != rsp_code(r_cmd)) begin
            w_frame_err = 1'b1;
          end
        end else if (r_core_err || r_idx == rx_last(r_cmd)) begin
          if (w_rx_byte != RSP_EOC) begin
            w_frame_err = 1'b1;
          end else begin
            w_state_next     = ST_DONE;
            w_status_next    = r_core_err ? STATUS_CORE_ERR : STATUS_OK;
            w_resp_data_next = (!r_core_err && r_cmd == REQ_READ) ? r_rdata : 32'h0;
          end
        end else if (r_idx == 4'd2) begin
          if (w_rx_byte != r_addr[15:8]) w_frame_err = 1'b1;
        end else if (r_idx == 4'd3) begin
          if (w_rx_byte != r_addr[7:0]) w_frame_err = 1'b1;
        end else begin
          w_rdata_next = {r_rdata[23:0], w_rx_byte};
        end
        if (w_frame_err) begin
          w_status_next    = STATUS_FRAME_ERR;
          w_resp_data_next = 32'h0;
          w_state_next     = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign o_req_ready      = (r_state == ST_IDLE);
  assign o_busy           = (r_state != ST_IDLE);
  assign o_tx_syn         = (r_state == ST_TX_BYTE);
  assign o_tx_data        = (r_state == ST_TX_BYTE) ? w_tx_byte : 8'h00;
  assign o_resp_valid     = (r_state == ST_DONE);
  assign o_resp_status    = r_status;
  assign o_resp_read_data = r_resp_data;

endmodule

// File: doc/coretest_host.md
Name: coretest_host

Overview:
- Host-side counterpart of the coretest command engine, for on-FPGA loopback and self-test.
- Accepts one register request at a time (read, write or core reset). Serialises it into a coretest command frame on a byte syn/ack transmit interface, then parses the returned response frame from a byte syn/ack receive interface.
- Sits between a local test sequencer and a uart instance, or connects directly to a coretest instance in simulation.

Parameters:
- TIMEOUT_CYCLES, 32'd1000000: maximum clk cycles between response bytes before the request is aborted.
- SOC, 8'h55: command start-of-command byte.
- EOC, 8'haa: command end-of-command byte.
- RSP_SOC, 8'haa: response start byte.
- RSP_EOC, 8'h55: response end byte.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request strobe, accepted when req_ready=1.
- req_ready  out  1  high in IDLE only.
- req_cmd  in  2  request type: 0=READ (0x10), 1=WRITE (0x11), 2=RESET (0x01), 3=reserved (treated as READ).
- req_address  in  16  core address {prefix, offset}.
- req_write_data  in  32  write data, big-endian on the wire.
- resp_valid  out  1  one-cycle pulse at request completion.
- resp_status  out  2  0=OK, 1=CORE_ERR (0xfd or 0xfe received), 2=FRAME_ERR, 3=TIMEOUT.
- resp_read_data  out  32  read data; valid with resp_valid for an OK read.
- tx_syn  out  1  transmit byte valid.
- tx_data  out  8  transmit byte.
- tx_ack  in  1  transmit byte accepted.
- rx_syn  in  1  receive byte valid.
- rx_data  in  8  receive byte.
- rx_ack  out  1  receive byte accepted.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0 except req_ready=1. FSM=IDLE; counters and data registers cleared. Reset mid-frame aborts immediately with no resp_valid and no partial byte.
- Byte handshake, transmit side:
  - tx_syn rises with tx_data stable.
  - A byte is transferred on the first clk where tx_syn&&tx_ack.
  - tx_syn drops the next cycle. The next byte is presented no earlier than the cycle after tx_ack is seen low.
- Byte handshake, receive side:
  - On rx_syn=1 with rx_ack=0, the byte is registered and rx_ack is pulsed high for exactly one cycle.
  - A new byte is accepted only after rx_syn has been seen low.
- Request capture: on req_valid&&req_ready, req_cmd, req_address and req_write_data are latched. Next state is TX_BYTE with byte index 0.
- Command frames, sent MSB byte first:
  - READ: SOC,10,ah,al,EOC (5 bytes).
  - WRITE: SOC,11,ah,al,d3,d2,d1,d0,EOC (9 bytes).
  - RESET: SOC,01,EOC (3 bytes).
- FSM:
  - IDLE -> TX_BYTE.
  - TX_BYTE (present byte[idx]) -> TX_WAIT on handshake. TX_WAIT -> TX_BYTE on tx_ack low with idx+1, or -> RX_BYTE after the last byte.
  - RX_BYTE -> PARSE on each received byte. PARSE -> RX_BYTE until the frame end, then -> DONE. DONE drives resp_valid for one cycle, then -> IDLE.
- Expected response frames:
  - READ: RSP_SOC,7f,ah,al,d3,d2,d1,d0,RSP_EOC.
  - WRITE: RSP_SOC,7e,ah,al,RSP_EOC.
  - RESET: RSP_SOC,7d,RSP_EOC.
  - Error: RSP_SOC,fd|fe,RSP_EOC gives status CORE_ERR.
- FRAME_ERR conditions, each terminating the request immediately:
  - first byte not RSP_SOC;
  - response code not matching the command and not fd/fe;
  - echoed address not equal to the latched address;
  - final byte not RSP_EOC.
- On any non-OK status, resp_read_data=0.
- Timeout: a counter clears on each received byte and on entry to RX_BYTE. It increments only in RX_BYTE. When it reaches TIMEOUT_CYCLES-1: status TIMEOUT, go to DONE.
- Bytes arriving in IDLE or TX states are acknowledged and discarded.
- req_valid while busy is ignored; there is no queue.
- resp_read_data holds until the next resp_valid.

Decomposition:
- Package coretest_pkg holds:
  - command codes 8'h10, 8'h11, 8'h01;
  - response codes 8'h7f, 8'h7e, 8'h7d, 8'hfd, 8'hfe;
  - the SOC/EOC values;
  - resp_status encodings;
  - FSM state encodings.
- The receive-side syn/ack byte acceptor (register plus one-cycle ack, rx_syn-low rearm) is one natural sub-module: coretest_byte_rx.

Test Plan:
- READ 0x1020, responder returns aa,7f,10,20,de,ad,be,ef,55 -> tx bytes 55,10,10,20,aa; resp_valid with status 0, data 0xdeadbeef.
- WRITE 0x0008 with data 0x12345678, responder returns aa,7e,00,08,55 -> tx 55,11,00,08,12,34,56,78,aa; status 0.
- READ, responder returns aa,fd,55 -> status 1, data 0; FSM back in IDLE with req_ready=1.
- READ 0x1000, response address echo 10,01 -> status 2 immediately after that byte.
- Responder silent, TIMEOUT_CYCLES=100 -> resp_valid exactly 100 cycles after the last tx byte completes, status 3.
- tx_ack held off 7 cycles per byte, plus reset_n pulsed low mid-WRITE -> byte order preserved under back-pressure; after reset, tx_syn=0, busy=0, no resp_valid.
